// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   - default address/data widths and the width of the internal counters
//   - arbiter state encoding (IDLE / ACCESS / RESP)
//   - access owner encoding (fetch stage vs. load/store path)
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  // Wait-state and starvation counts both fit in 0..15.
  localparam int CNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of every signal between the arbiter, its two
// requesters (IF fetch, D load/store) and the single-ported memory.
//   IF side : if_req, if_addr -> ; <- if_rdata, if_ready, if_stall
//   D side  : d_req, d_we, d_addr, d_wdata -> ; <- d_rdata, d_ready, d_stall
//   memory  : <- mem_en, mem_we, mem_addr, mem_wdata ; mem_rdata ->
// Modport slave is the arbiter's view; master is the requester/memory view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ready;
  logic                  if_stall;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ready;
  logic                  d_stall;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// mem_wait_counter: loadable down-counter with a zero flag.
//   clk, reset  : clock, asynchronous active-high reset (count <= RESET_VAL)
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one; holds at zero instead of wrapping
//   o_zero      : count is zero
module mem_wait_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch stage
// (IF) and the load/store path (D). Each access is IDLE -> ACCESS (WAIT_STATES+1
// cycles) -> RESP (one-cycle ready pulse to the owner). D wins ties.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mem_port_arbiter_if.slave (requesters, memory, stall outputs)
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive D grants
// made while IF was waiting, IF wins the next arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] C_WAIT = CNT_WIDTH'(WAIT_STATES);

  state_t                r_state,     w_state_next;
  owner_t                r_owner,     w_owner_next;
  logic                  r_mem_en,    w_mem_en_next;
  logic                  r_mem_we,    w_mem_we_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_next;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_next;
  logic [DATA_WIDTH-1:0] r_if_rdata,  w_if_rdata_next;
  logic [DATA_WIDTH-1:0] r_d_rdata,   w_d_rdata_next;
  logic                  r_if_ready,  w_if_ready_next;
  logic                  r_d_ready,   w_d_ready_next;

  logic w_wait_load, w_wait_dec, w_wait_zero;
  logic w_force_if, w_pick_d, w_pick_if, w_grant_d, w_grant_if;

  mem_wait_counter #(
    .WIDTH     (CNT_WIDTH),
    .RESET_VAL ({CNT_WIDTH{1'b0}})
  ) u_wait (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_wait_load),
    .i_load_val (C_WAIT),
    .i_dec      (w_wait_dec),
    .o_zero     (w_wait_zero)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [CNT_WIDTH-1:0] C_STARVE = CNT_WIDTH'(STARVE_LIMIT);
  logic w_starve_zero;

  // Counts down from STARVE_LIMIT on each D grant taken while IF is waiting;
  // reaching zero means IF has been passed over STARVE_LIMIT times in a row.
  mem_wait_counter #(
    .WIDTH     (CNT_WIDTH),
    .RESET_VAL (C_STARVE)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_grant_if),
    .i_load_val (C_STARVE),
    .i_dec      (w_grant_d & bus.if_req),
    .o_zero     (w_starve_zero)
  );

  assign w_force_if = bus.if_req & w_starve_zero;
`else
  assign w_force_if = 1'b0;
`endif

  assign w_pick_d   = bus.d_req & ~w_force_if;
  assign w_pick_if  = bus.if_req & ~w_pick_d;
  assign w_grant_d  = (r_state == ST_IDLE) & w_pick_d;
  assign w_grant_if = (r_state == ST_IDLE) & w_pick_if;

  always_comb begin
    w_state_next     = r_state;
    w_owner_next     = r_owner;
    w_mem_en_next    = r_mem_en;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_if_rdata_next  = r_if_rdata;
    w_d_rdata_next   = r_d_rdata;
    w_if_ready_next  = 1'b0;
    w_d_ready_next   = 1'b0;
    w_wait_load      = 1'b0;
    w_wait_dec       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_owner_next     = OWN_D;
          w_mem_addr_next  = bus.d_addr;
          w_mem_wdata_next = bus.d_wdata;
          w_mem_we_next    = bus.d_we;
        end else if (w_grant_if) begin
          w_owner_next     = OWN_IF;
          w_mem_addr_next  = bus.if_addr;
          w_mem_wdata_next = '0;
          w_mem_we_next    = 1'b0;
        end
        if (w_grant_d || w_grant_if) begin
          w_mem_en_next = 1'b1;
          w_wait_load   = 1'b1;
          w_state_next  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (!w_wait_zero) begin
          w_wait_dec = 1'b1;
        end else begin
          // Last access cycle: memory data is valid now. Stores leave rdata alone.
          if (!r_mem_we) begin
            if (r_owner == OWN_D) w_d_rdata_next  = bus.mem_rdata;
            else                  w_if_rdata_next = bus.mem_rdata;
          end
          w_if_ready_next = (r_owner == OWN_IF);
          w_d_ready_next  = (r_owner == OWN_D);
          w_mem_en_next   = 1'b0;
          w_mem_we_next   = 1'b0;
          w_state_next    = ST_RESP;
        end
      end

      ST_RESP: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_if_rdata  <= w_if_rdata_next;
      r_d_rdata   <= w_d_rdata_next;
      r_if_ready  <= w_if_ready_next;
      r_d_ready   <= w_d_ready_next;
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.d_ready   = r_d_ready;
  assign bus.if_stall  = bus.if_req & ~r_if_ready;
  assign bus.d_stall   = bus.d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed steps followed by random traffic,
// every cycle compared with a transaction-timing reference model.
module tb_mem_port_arbiter;

  localparam int W  = 1;
  localparam int SL = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(W), .STARVE_LIMIT(SL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Second instance exercising the zero-wait-state boundary.
  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0), .STARVE_LIMIT(SL)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  // Memory device: data is only valid in the W-th cycle after mem_en rises.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  int mem_age;
  always @(posedge clk or posedge reset) begin
    if (reset)            mem_age <= 0;
    else if (bus.mem_en)  mem_age <= mem_age + 1;
    else                  mem_age <= 0;
  end
  assign bus.mem_rdata  = (bus.mem_en && mem_age == W) ? mem_val(bus.mem_addr) : 32'hBAAD_F00D;
  assign bus0.mem_rdata = bus0.mem_en ? mem_val(bus0.mem_addr) : 32'hBAAD_F00D;

  // Reference model: m_t = cycles since the grant edge (0 = idle).
  // Access cycles are 1..W+1, response cycle is W+2, then idle again.
  int          m_t;
  logic        m_own_d;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
`ifdef ARB_STARVE_GUARD_EN
  int          m_starve;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_own_d = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
`ifdef ARB_STARVE_GUARD_EN
    m_starve = 0;
`endif
  endtask

  task automatic model_edge();
    logic force_if, pick_d, pick_if;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_t == 0) begin
      force_if = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      force_if = bus.if_req && (m_starve == SL);
`endif
      pick_d  = bus.d_req && !force_if;
      pick_if = bus.if_req && !pick_d;
      if (pick_d) begin
        m_t = 1; m_own_d = 1'b1; m_addr = bus.d_addr; m_we = bus.d_we; m_wdata = bus.d_wdata;
`ifdef ARB_STARVE_GUARD_EN
        if (bus.if_req && m_starve < SL) m_starve++;
`endif
      end else if (pick_if) begin
        m_t = 1; m_own_d = 1'b0; m_addr = bus.if_addr; m_we = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        m_starve = 0;
`endif
      end
    end else begin
      if (m_t == W + 1 && !m_we) begin
        if (m_own_d) m_d_rdata  = mem_val(m_addr);
        else         m_if_rdata = mem_val(m_addr);
      end
      m_t = (m_t == W + 2) ? 0 : m_t + 1;
    end
  endtask

  task automatic check_outputs();
    logic e_en, e_if_rdy, e_d_rdy;
    e_en     = (m_t >= 1) && (m_t <= W + 1);
    e_if_rdy = (m_t == W + 2) && !m_own_d;
    e_d_rdy  = (m_t == W + 2) && m_own_d;
    chk("mem_en",   32'(bus.mem_en),   32'(e_en));
    chk("mem_we",   32'(bus.mem_we),   32'(e_en & m_we));
    chk("if_ready", 32'(bus.if_ready), 32'(e_if_rdy));
    chk("d_ready",  32'(bus.d_ready),  32'(e_d_rdy));
    chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req & ~e_if_rdy));
    chk("d_stall",  32'(bus.d_stall),  32'(bus.d_req & ~e_d_rdy));
    chk("if_rdata", bus.if_rdata, m_if_rdata);
    chk("d_rdata",  bus.d_rdata,  m_d_rdata);
    if (e_en)         chk("mem_addr",  bus.mem_addr,  m_addr);
    if (e_en && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (m_t == W + 2)
      $display("txn %s addr=%h we=%0d data=%h", m_own_d ? "D " : "IF", m_addr, m_we,
               m_we ? m_wdata : (m_own_d ? m_d_rdata : m_if_rdata));
  endtask

  task automatic fetch_test(input string tag);
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
    #1 chk({tag, "_stall0"}, 32'(bus.if_stall), 32'd1);
    cycle(); chk({tag, "_en1"}, 32'(bus.mem_en), 32'd1); chk({tag, "_stall1"}, 32'(bus.if_stall), 32'd1);
    cycle(); chk({tag, "_en2"}, 32'(bus.mem_en), 32'd1); chk({tag, "_stall2"}, 32'(bus.if_stall), 32'd1);
    cycle(); chk({tag, "_rdy"}, 32'(bus.if_ready), 32'd1); chk({tag, "_en3"}, 32'(bus.mem_en), 32'd0);
    chk({tag, "_rdata"}, bus.if_rdata, 32'h2008_0005);
    bus.if_req = 1'b0;
    cycle(); chk({tag, "_rdy_once"}, 32'(bus.if_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_if, n_d;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus0.if_req = 0; bus0.if_addr = '0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = '0; bus0.d_wdata = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();

    // Reset state.
    @(negedge clk);
    check_outputs();
    chk("rst_mem_addr",  bus.mem_addr,  32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_state_en0", 32'(bus0.mem_en), 32'd0);
    cycle();
    reset = 1'b0;
    cycle();

    // 1: single fetch.
    fetch_test("t1");

    // 2: simultaneous requests, D wins, IF served after D's response.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1001_0004;
    bus.if_req = 1; bus.if_addr = 32'h0040_0010;
    cycle(); cycle(); cycle();
    chk("t2_d_rdy", 32'(bus.d_ready), 32'd1);
    chk("t2_if_rdy_lo", 32'(bus.if_ready), 32'd0);
    chk("t2_d_rdata", bus.d_rdata, mem_val(32'h1001_0004));
    bus.d_req = 0;
    cycle(); cycle(); cycle(); cycle();
    chk("t2_if_rdy", 32'(bus.if_ready), 32'd1);
    chk("t2_if_rdata", bus.if_rdata, mem_val(32'h0040_0010));
    bus.if_req = 0;
    cycle();

    // 3: store leaves d_rdata unchanged.
    bus.d_req = 1; bus.d_we = 1; bus.d_wdata = 32'hDEAD_BEEF; bus.d_addr = 32'h1001_0000;
    cycle(); chk("t3_we1", 32'(bus.mem_we), 32'd1); chk("t3_wd1", bus.mem_wdata, 32'hDEAD_BEEF);
    cycle(); chk("t3_we2", 32'(bus.mem_we), 32'd1); chk("t3_wd2", bus.mem_wdata, 32'hDEAD_BEEF);
    cycle(); chk("t3_rdy", 32'(bus.d_ready), 32'd1); chk("t3_we3", 32'(bus.mem_we), 32'd0);
    chk("t3_rdata_kept", bus.d_rdata, mem_val(32'h1001_0004));
    bus.d_req = 0;
    cycle();

    // 4: reset in the second access cycle of a store.
    bus.d_req = 1; bus.d_we = 1; bus.d_wdata = 32'h0BAD_CAFE; bus.d_addr = 32'h1001_0008;
    cycle(); chk("t4_we1", 32'(bus.mem_we), 32'd1);
    @(posedge clk);
    model_edge();
    #2 chk("t4_we2", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    #1 chk("t4_rst_en", 32'(bus.mem_en), 32'd0);
    chk("t4_rst_we", 32'(bus.mem_we), 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs();
    bus.d_req = 0;
    cycle();
    reset = 1'b0;
    cycle(); cycle();
    fetch_test("t4");

    // Requester drops req mid-access: the access still completes.
    bus.if_req = 1; bus.if_addr = 32'h0040_0020;
    cycle(); bus.if_req = 0;
    cycle(); cycle();
    chk("drop_rdy", 32'(bus.if_ready), 32'd1);
    chk("drop_rdata", bus.if_rdata, mem_val(32'h0040_0020));
    cycle();

    // 5: continuous D traffic with IF waiting.
    bus.d_we = 0; bus.d_addr = 32'h1001_0100; bus.d_req = 1;
    bus.if_addr = 32'h0040_0100; bus.if_req = 1;
    n_if = 0; n_d = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.if_ready) n_if++;
      if (bus.d_ready)  n_d++;
      bus.d_addr = 32'h1001_0100 + 32'(4 * i);
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("t5_if_grants", 32'(n_if), 32'd1);
    chk("t5_d_grants",  32'(n_d),  32'd4);
`else
    chk("t5_if_grants", 32'(n_if), 32'd0);
    chk("t5_d_grants",  32'(n_d),  32'd5);
`endif
    bus.d_req = 0; bus.if_req = 0;
    cycle(); cycle(); cycle();

    // 6: zero wait states, back-to-back fetches.
    bus0.if_req = 1; bus0.if_addr = 32'h0040_0200;
    for (int n = 1; n <= 12; n++) begin
      cycle();
      chk("t6_rdy", 32'(bus0.if_ready), 32'(n % 3 == 2));
      chk("t6_en",  32'(bus0.mem_en),   32'(n % 3 == 1));
      if (n % 3 == 2) chk("t6_rdata", bus0.if_rdata, mem_val(32'h0040_0200));
    end
    bus0.if_req = 0;
    cycle();

    // Random traffic; requesters hold req until their ready, addresses may wobble.
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (bus.if_req) begin
        if (m_t == W + 2 && !m_own_d) begin
          bus.if_req  = ($urandom_range(1, 0) == 1);
          bus.if_addr = $urandom;
        end else if ($urandom_range(7, 0) == 0) begin
          bus.if_addr = $urandom;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        bus.if_req = 1; bus.if_addr = $urandom;
      end
      if (bus.d_req) begin
        if (m_t == W + 2 && m_own_d) begin
          bus.d_req = ($urandom_range(1, 0) == 1);
          bus.d_we = $urandom_range(1, 0); bus.d_addr = $urandom; bus.d_wdata = $urandom;
        end else if ($urandom_range(7, 0) == 0) begin
          bus.d_addr = $urandom; bus.d_wdata = $urandom;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        bus.d_req = 1; bus.d_we = $urandom_range(1, 0); bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
    end
    bus.if_req = 0; bus.d_req = 0;
    cycle(); cycle(); cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch stage (IF) and the load/store path (D) of the MIPS core.
- Sequences each access through a fixed wait-state window and returns registered read data with a one-cycle ready pulse.
- Emits stall signals that freeze the PC and pipeline while a requester waits.
- D requests are driven by the control unit's MemRead/MemWrite.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory word width.
- WAIT_STATES, 1, extra cycles memory needs after address presentation; legal range 0..15.
- STARVE_LIMIT, 3, consecutive D grants while IF waits before IF is forced (feature only); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high.
- if_rdata  out  DATA_WIDTH  fetched instruction; valid when if_ready is high.
- if_ready  out  1  one-cycle completion pulse for IF.
- d_req  in  1  data request (MemRead|MemWrite); held until d_ready.
- d_we  in  1  1 = store, 0 = load; stable with d_req.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data; valid when d_ready is high.
- d_ready  out  1  one-cycle completion pulse for D.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid in the last ACCESS cycle.
- if_stall  out  1  if_req & ~if_ready (combinational).
- d_stall  out  1  d_req & ~d_ready (combinational).

Behaviour:
- Reset values (async, immediate): state=IDLE; counter 0; owner=IF; mem_en, mem_we, if_ready, d_ready all 0; mem_addr, mem_wdata, if_rdata, d_rdata all 0.
- States:
  - IDLE: if d_req, grant D; else if if_req, grant IF; else stay. On grant, register mem_addr/mem_wdata/mem_we (mem_we = d_we for D, 0 for IF), set mem_en=1, counter=WAIT_STATES, go to ACCESS.
  - ACCESS: mem_* held stable. If counter != 0, decrement. If counter == 0, capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave rdata unchanged), drop mem_en/mem_we, go to RESP.
  - RESP: the owner's ready is 1 for exactly this cycle, then go to IDLE. No grant is made in RESP.
- Latency: request sampled in IDLE at edge k -> ready high in cycle k+WAIT_STATES+2. Minimum spacing between grants is WAIT_STATES+3 cycles.
- if_ready and d_ready are never high in the same cycle. The non-owner's rdata holds its last value.
- Simultaneous if_req and d_req in IDLE: D wins.
- Requester drops req mid-access: the access still completes and ready still pulses. No abort.
- Address changes mid-access are ignored; only the registered copy is used.
- Reset asserted mid-access: immediate return to IDLE. A write in progress is truncated (mem_we falls asynchronously). No ready is issued.
- WAIT_STATES=0: ACCESS lasts exactly one cycle.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined: a saturating counter counts D grants made while if_req is high; it clears on any IF grant. When the count equals STARVE_LIMIT, IF wins the next IDLE arbitration even if d_req is high.
- Undefined: strict D priority; the counter logic is absent. IF can starve indefinitely under continuous D traffic.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - owner encoding (OWN_IF=1'b0, OWN_D=1'b1);
  - default widths.
- One natural sub-module, mem_wait_counter: a loadable down-counter with a zero flag, instantiated for the wait states and reused for the starvation count.

Test Plan:
1. WAIT_STATES=1; if_req=1, if_addr=0x0040_0000, mem returns 0x2008_0005 -> mem_en high 2 cycles; if_ready pulses in cycle 3 after the sampling edge; if_rdata=0x2008_0005; if_stall high cycles 0-2.
2. if_req and d_req both rise together, d_we=0, d_addr=0x1001_0004 -> D served first (d_ready at cycle 3); IF granted in the IDLE cycle after RESP (if_ready at cycle 7).
3. Store: d_req=1, d_we=1, d_wdata=0xDEAD_BEEF, d_addr=0x1001_0000 -> mem_we=1 for WAIT_STATES+1 cycles with that data; d_rdata unchanged; d_ready pulses once.
4. Reset asserted in the second ACCESS cycle of a store -> mem_en and mem_we drop the same cycle; no ready; the next request after release behaves as in test 1.
5. ARB_STARVE_GUARD_EN, STARVE_LIMIT=3; d_req held high continuously with if_req high -> three D grants, then an IF grant, then D resumes. Without the macro, no IF grant occurs.
6. WAIT_STATES=0; back-to-back IF requests -> if_ready exactly every 3 cycles; mem_en is never high in a RESP cycle.
